uart_tx_param: RTL and testbench

//  Parametrised UART serialiser: accepts a word on a valid/ready handshake and transmits one framed character
//  (start, DATA_W data bits LSB first, optional parity, 1 or 2 stop bits), each bit held CLKS_PER_BIT cycles.
//  It is the transmit side of the UART datapath and drives the serial line directly.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_param_baud_tick.sv | 28 ++
 rtl/uart_tx_param.sv | 127 ++++++++++++
 tb/tb_uart_tx_param.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and
// frame-length helper. The receiver will reuse this package.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    // Number of serial bits in one character, start and stop bits included.
    function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
        return 1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_param_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. Clearing on accept aligns the count to the start-bit edge.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] bit_cnt;

    assign tick = (bit_cnt == LAST);

    // Free-running bit counter, wrapping on the last cycle or on clear.
    always_ff @(posedge clk) begin
        if (rst || clear || tick)
            bit_cnt <= '0;
        else
            bit_cnt <= bit_cnt + ONE;
    end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter: accepts a word on valid/ready and serialises one frame
// (start, data LSB first, optional parity, 1 or 2 stop bits) onto tx.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_param: DATA_W must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end

    tx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic [IDX_W-1:0]  bit_idx;
    logic              stop_cnt;
    logic              tick;
    logic              accept;

    assign tx_ready = (state == S_IDLE);
    assign accept   = tx_valid && tx_ready;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .tick  (tick)
    );

    // Frame sequencer with registered line and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        state    <= S_START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        shreg    <= tx_data;
                        par_bit  <= (PARITY == PAR_ODD) ? ~(^tx_data) : ^tx_data;
                        bit_idx  <= '0;
                        stop_cnt <= 1'b0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        state <= S_DATA;
                        tx    <= shreg[0];
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_IDX) begin
                            if (PARITY != PAR_NONE) begin
                                state <= S_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_ONE;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (stop_cnt == STOP_LAST) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameterisations, frame bit
// patterns checked every cycle against hand-written expected sequences.
module tb_uart_tx_param;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d8 [3];
    logic [4:0] d5;
    logic       vld [4];
    logic       rdy_v [4];
    logic       tx_v [4];
    logic       busy_v [4];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         t0, t1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .tx_data(d8[0]), .tx_valid(vld[0]),
        .tx_ready(rdy_v[0]), .tx(tx_v[0]), .busy(busy_v[0]));
    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .tx_data(d8[1]), .tx_valid(vld[1]),
        .tx_ready(rdy_v[1]), .tx(tx_v[1]), .busy(busy_v[1]));
    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .tx_data(d8[2]), .tx_valid(vld[2]),
        .tx_ready(rdy_v[2]), .tx(tx_v[2]), .busy(busy_v[2]));
    uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(2), .PARITY(1), .STOP_BITS(1)) u3 (
        .clk(clk), .rst(rst), .tx_data(d5), .tx_valid(vld[3]),
        .tx_ready(rdy_v[3]), .tx(tx_v[3]), .busy(busy_v[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int idx, input string tag);
        chk({tag, " tx"}, 32'(tx_v[idx]), 32'd1);
        chk({tag, " busy"}, 32'(busy_v[idx]), 32'd0);
        chk({tag, " ready"}, 32'(rdy_v[idx]), 32'd1);
    endtask

    // Present one word; returns at the falling edge of the first start-bit cycle.
    task automatic send(input int idx, input logic [7:0] d);
        @(negedge clk);
        chk($sformatf("u%0d ready before send", idx), 32'(rdy_v[idx]), 32'd1);
        if (idx == 3) d5 = d[4:0];
        else d8[idx] = d;
        vld[idx] = 1'b1;
        @(negedge clk);
        vld[idx] = 1'b0;
    endtask

    // Walk a frame cycle by cycle; pat lists line bits in send order, '|' is a separator.
    // Returns at the falling edge of the idle cycle after the frame.
    task automatic check_frame(input int idx, input int cpb, input string pat, input string tag);
        int nb = 0;
        for (int i = 0; i < pat.len(); i++) begin
            if (pat.getc(i) != "|") begin
                for (int c = 0; c < cpb; c++) begin
                    chk($sformatf("%s bit%0d c%0d tx", tag, nb, c), 32'(tx_v[idx]),
                        32'(pat.getc(i) == "1"));
                    chk($sformatf("%s bit%0d c%0d busy", tag, nb, c), 32'(busy_v[idx]), 32'd1);
                    @(negedge clk);
                end
                nb++;
            end
        end
        chk_idle(idx, {tag, " idle"});
    endtask

    initial begin
        for (int i = 0; i < 4; i++) vld[i] = 1'b0;
        for (int i = 0; i < 3; i++) d8[i] = 8'h00;
        d5 = 5'h00;

        // Reset state of every instance
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) chk_idle(i, $sformatf("reset u%0d", i));
        rst = 1'b0;
        @(negedge clk);

        // Test 1: even parity, 0xA5
        send(0, 8'hA5);
        check_frame(0, 4, "0|10100101|0|1", "t1 A5 even");
        chk("t1 frame length", 32'(frame_bits(8, PAR_EVEN, 1) * 4), 32'd44);

        // Test 2: odd parity; no parity with two stop bits
        send(1, 8'hA5);
        check_frame(1, 4, "0|10100101|1|1", "t2 A5 odd");
        send(2, 8'hA5);
        check_frame(2, 4, "0|10100101|1|1", "t2 A5 none 2stop");

        // Test 3: valid held high across two words
        @(negedge clk);
        chk("t3 ready", 32'(rdy_v[0]), 32'd1);
        vld[0] = 1'b1;
        d8[0] = 8'h00;
        @(negedge clk);
        t0 = cyc;
        d8[0] = 8'hFF;
        check_frame(0, 4, "0|00000000|0|1", "t3 00");
        @(negedge clk);
        t1 = cyc;
        vld[0] = 1'b0;
        chk("t3 start spacing", 32'(t1 - t0), 32'd45);
        check_frame(0, 4, "0|11111111|0|1", "t3 FF");

        // Test 4: 5 data bits, 2 clocks per bit, even parity
        send(3, 8'hF3);
        check_frame(3, 2, "0|11001|1|1", "t4 5b");

        // Test 5: reset in data bit 3 of 0x3C, then a clean 0x81
        send(0, 8'h3C);
        begin
            string pre = "0000000000001111";
            for (int k = 0; k < 16; k++) begin
                chk($sformatf("t5 pre c%0d tx", k), 32'(tx_v[0]), 32'(pre.getc(k) == "1"));
                @(negedge clk);
            end
        end
        chk("t5 bit3 tx", 32'(tx_v[0]), 32'd1);
        chk("t5 bit3 busy", 32'(busy_v[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle(0, "t5 after rst");
        send(0, 8'h81);
        check_frame(0, 4, "0|10000001|0|1", "t5 81");

        // Test 6: inputs toggled while busy; next word taken only when ready
        send(0, 8'h5A);
        fork
            check_frame(0, 4, "0|01011010|0|1", "t6 5A");
            begin
                for (int i = 0; i < 43; i++) begin
                    vld[0] = i[0];
                    d8[0] = 8'($urandom);
                    @(negedge clk);
                end
                d8[0] = 8'hC3;
                vld[0] = 1'b1;
            end
        join
        @(negedge clk);
        vld[0] = 1'b0;
        check_frame(0, 4, "0|11000011|0|1", "t6 C3");
        repeat (2) @(negedge clk);
        chk_idle(0, "t6 final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
